// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the two-port memory arbiter.
// Holds the FSM state encoding, requester port indices, the width of
// the optional timeout counter and the round-robin pick function.
package mem_arb_pkg;

  // FSM state encoding (plain constants so legacy tools can read them).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  // Requester port indices; also the value driven onto the mux select.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Width of the BUSY wait counter used by the optional timeout.
  localparam int TMO_CNT_W = 8;

  // Result of one arbitration decision taken in IDLE.
  typedef struct packed {
    logic valid;  // at least one port is requesting
    logic port;   // winning port index
  } arb_pick_t;

  // Round-robin pick: a lone requester always wins; when both request,
  // the port that was not granted last time wins.
  function automatic arb_pick_t rr_pick(input logic req0,
                                        input logic req1,
                                        input logic last_grant);
    arb_pick_t pick;
    pick.valid = req0 | req1;
    if (req0 && req1) begin
      pick.port = ~last_grant;
    end else if (req1) begin
      pick.port = PORT_DATA;
    end else begin
      pick.port = PORT_FETCH;
    end
    return pick;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mux2to1_32bit.sv
// 32-bit 2:1 multiplexer used to steer the requester address onto the
// shared memory bus. sel_i = 0 selects in0_i, sel_i = 1 selects in1_i.
module mux2to1_32bit (
  input  logic [31:0] in0_i,
  input  logic [31:0] in1_i,
  input  logic        sel_i,
  output logic [31:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule : mux2to1_32bit

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction
// fetch (port 0) and data load/store (port 1). An IDLE/BUSY0/BUSY1 FSM
// picks a requester, drives the address mux select, and returns a
// one-cycle ack with read data when the memory completes the access.
//
// Optional feature: define MEM_PORT_TIMEOUT_EN to abort a BUSY access
// after TIMEOUT_CYCLES cycles without mem_ready; the abort is reported
// as an ack with err=1 and rdata=0. Without the macro err is tied low
// and BUSY waits for mem_ready indefinitely.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  // Port 0: instruction fetch
  input  logic        req0,
  input  logic [31:0] addr0,
  // Port 1: data load/store
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  // Requester responses
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  // Memory bus
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Elaboration-time guard: the wait counter can only reach 255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TMO_CNT_W) - 1) begin : g_bad_timeout_cycles
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_grant_q, last_grant_d;

  arb_pick_t  pick;
  logic       in_busy0;
  logic       in_busy1;
  logic       busy;
  logic       timeout;
  logic       done;

  assign in_busy0 = (state_q == BUSY0);
  assign in_busy1 = (state_q == BUSY1);
  assign busy     = in_busy0 | in_busy1;

  // A BUSY access ends when memory completes it or the timeout fires.
  assign done     = busy & (mem_ready | timeout);

  // Arbitration decision, only acted upon in IDLE.
  always_comb begin
    pick = rr_pick(req0, req1, last_grant_q);
  end

  // Next-state logic for the FSM, the mux select and the round-robin pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          state_d      = (pick.port == PORT_DATA) ? BUSY1 : BUSY0;
          sel_d        = pick.port;
          last_grant_d = pick.port;
        end
      end
      BUSY0, BUSY1: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state registers; reset makes port 0 the first winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= PORT_FETCH;
      last_grant_q <= PORT_DATA;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef MEM_PORT_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Wait counter: held at zero in IDLE so it starts cleared on BUSY entry,
  // then counts BUSY cycles that end without mem_ready.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!busy) begin
      wait_cnt_d = '0;
    end else if (!mem_ready && !timeout) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Abort on the last allowed cycle unless memory completes in that cycle.
  assign timeout = busy & ~mem_ready & (wait_cnt_q == TMO_LAST);
  assign err     = timeout;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Address steering onto the memory bus through the shared 32-bit mux.
  mux2to1_32bit u_addr_mux (
    .in0_i (addr0),
    .in1_i (addr1),
    .sel_i (sel_q),
    .out_o (mem_addr)
  );

  // Memory bus controls: only the data port ever writes.
  assign mem_req   = busy;
  assign mem_we    = we1 & in_busy1;
  assign mem_wdata = in_busy1 ? wdata1 : 32'd0;

  // Requester responses: acks pulse in the completing cycle; read data
  // passes through only on a real completion, never on an abort.
  assign ack0  = in_busy0 & done;
  assign ack1  = in_busy1 & done;
  assign rdata = (done && mem_ready) ? mem_rdata : 32'd0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of per-cycle
// {inputs, expected outputs} records plus hand-written sequences for
// reset values, reset during BUSY and the optional timeout
// (MEM_PORT_TIMEOUT_EN, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

  localparam logic [31:0] A0 = 32'h0040_0000;
  localparam logic [31:0] A1 = 32'h1001_0000;
  localparam logic [31:0] A2 = 32'h1001_0008;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;
  localparam logic [31:0] W1 = 32'h1111_1111;
  localparam logic [31:0] RD = 32'h8C08_0004;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ready = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata1 = '0, mem_rdata = '0;
  logic        ack0, ack1, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        r0, r1, we, rdy;
    logic [31:0] a0, a1, wd, mrd;
    logic        e_req, e_we, e_ack0, e_ack1;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[$];

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .addr0     (addr0),
    .req1      (req1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .we1       (we1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r0, input logic r1, input logic we, input logic rdy,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] wd, input logic [31:0] mrd,
                     input logic ereq, input logic ewe, input logic eack0, input logic eack1,
                     input logic [31:0] eaddr, input logic [31:0] ewdata, input logic [31:0] erdata);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we = we; v.rdy = rdy;
    v.a0 = a0; v.a1 = a1; v.wd = wd; v.mrd = mrd;
    v.e_req = ereq; v.e_we = ewe; v.e_ack0 = eack0; v.e_ack1 = eack1;
    v.e_addr = eaddr; v.e_wdata = ewdata; v.e_rdata = erdata;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
    addr0 = A0; addr1 = A1; wdata1 = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // One row per cycle: inputs applied at negedge, outputs checked 1 time unit later.
    //   r0 r1 we rdy  a0  a1  wdata1 mem_rdata     | req we ack0 ack1 mem_addr mem_wdata rdata
    // Both ports requesting from reset: grants 0,1,0,1, ack every 2 cycles.
    add(1, 1, 0, 1, A0, A1, W1, 32'hA000_0000,  0, 0, 0, 0, A0, 0,  0);
    add(1, 1, 0, 1, A0, A1, W1, RD,             1, 0, 1, 0, A0, 0,  RD);
    add(1, 1, 0, 1, A0, A1, W1, 32'hA000_0002,  0, 0, 0, 0, A0, 0,  0);
    add(1, 1, 0, 1, A0, A1, W1, 32'hB000_0003,  1, 0, 0, 1, A1, W1, 32'hB000_0003);
    add(1, 1, 0, 1, A0, A1, W1, 32'hC000_0004,  0, 0, 0, 0, A1, 0,  0);
    add(1, 1, 0, 1, A0, A1, W1, 32'hC000_0005,  1, 0, 1, 0, A0, 0,  32'hC000_0005);
    add(1, 1, 0, 1, A0, A1, W1, 32'hC000_0006,  0, 0, 0, 0, A0, 0,  0);
    add(1, 1, 0, 1, A0, A1, W1, 32'hC000_0007,  1, 0, 0, 1, A1, W1, 32'hC000_0007);
    // Idle with mem_ready high: ignored, select still points at port 1.
    add(0, 0, 0, 1, A0, A1, W1, 32'hC000_0008,  0, 0, 0, 0, A1, 0,  0);
    // Single fetch with memory already ready: ack one cycle after the request is seen.
    add(1, 0, 0, 1, A0, A1, W1, RD,             0, 0, 0, 0, A1, 0,  0);
    add(1, 0, 0, 1, A0, A1, W1, RD,             1, 0, 1, 0, A0, 0,  RD);
    add(0, 0, 0, 0, A0, A1, 0,  0,              0, 0, 0, 0, A0, 0,  0);
    // Data write with mem_ready low for 3 BUSY cycles; a fetch request arrives meanwhile.
    add(0, 1, 1, 0, A0, A2, WD, 0,              0, 0, 0, 0, A0, 0,  0);
    add(0, 1, 1, 0, A0, A2, WD, 0,              1, 1, 0, 0, A2, WD, 0);
    add(1, 1, 1, 0, A0, A2, WD, 0,              1, 1, 0, 0, A2, WD, 0);
    add(1, 1, 1, 0, A0, A2, WD, 0,              1, 1, 0, 0, A2, WD, 0);
    add(1, 1, 1, 1, A0, A2, WD, 32'hD000_0016,  1, 1, 0, 1, A2, WD, 32'hD000_0016);
    // Fetch granted, then req0 dropped while BUSY0: transaction still completes.
    add(1, 0, 0, 0, A0, A2, 0,  0,              0, 0, 0, 0, A2, 0,  0);
    add(0, 0, 0, 0, A0, A2, 0,  32'hE000_0018,  1, 0, 0, 0, A0, 0,  0);
    add(0, 0, 0, 1, A0, A2, 0,  32'hE000_0019,  1, 0, 1, 0, A0, 0,  32'hE000_0019);
    add(0, 0, 0, 1, A0, A2, 0,  32'hE000_0020,  0, 0, 0, 0, A0, 0,  0);

    // ---- Reset values, with requests and mem_ready active during reset ----
    clear_inputs();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b1; mem_ready = 1'b1;
    wdata1 = W1; mem_rdata = RD;
    #1;
    check("rst.mem_req",   mem_req,   0);
    check("rst.mem_we",    mem_we,    0);
    check("rst.ack0",      ack0,      0);
    check("rst.ack1",      ack1,      0);
    check("rst.err",       err,       0);
    check("rst.mem_addr",  mem_addr,  A0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.rdata",     rdata,     0);
    @(posedge clk); #1;
    check("rst.hold_mem_req", mem_req, 0);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;

    // ---- Table ----
    foreach (vecs[i]) begin
      @(negedge clk);
      req0 = vecs[i].r0; req1 = vecs[i].r1; we1 = vecs[i].we; mem_ready = vecs[i].rdy;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata1 = vecs[i].wd; mem_rdata = vecs[i].mrd;
      #1;
      check($sformatf("row%0d.mem_req", i),   mem_req,   vecs[i].e_req);
      check($sformatf("row%0d.mem_we", i),    mem_we,    vecs[i].e_we);
      check($sformatf("row%0d.ack0", i),      ack0,      vecs[i].e_ack0);
      check($sformatf("row%0d.ack1", i),      ack1,      vecs[i].e_ack1);
      check($sformatf("row%0d.mem_addr", i),  mem_addr,  vecs[i].e_addr);
      check($sformatf("row%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("row%0d.rdata", i),     rdata,     vecs[i].e_rdata);
      check($sformatf("row%0d.err", i),       err,       0);
    end

    // ---- Reset asserted in the middle of BUSY1 ----
    @(negedge clk);
    clear_inputs();
    req1 = 1'b1; we1 = 1'b1; addr1 = A2; wdata1 = WD;
    @(negedge clk); #1;
    check("midrst.busy_mem_req", mem_req, 1);
    check("midrst.busy_mem_we",  mem_we,  1);
    #2;
    reset_n = 1'b0;
    req0 = 1'b1;
    #1;
    check("midrst.async_mem_req",   mem_req,   0);
    check("midrst.async_mem_we",    mem_we,    0);
    check("midrst.async_ack1",      ack1,      0);
    check("midrst.async_mem_wdata", mem_wdata, 0);
    check("midrst.async_mem_addr",  mem_addr,  A0);
    mem_ready = 1'b1; mem_rdata = RD;
    @(posedge clk); #1;
    check("midrst.held_ack1", ack1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst.idle_mem_req", mem_req, 0);
    check("midrst.idle_ack0",    ack0,    0);
    check("midrst.idle_ack1",    ack1,    0);
    @(negedge clk); #1;
    check("midrst.first_grant_addr", mem_addr, A0);
    check("midrst.first_grant_ack0", ack0,     1);
    check("midrst.first_grant_ack1", ack1,     0);
    clear_inputs();

    // ---- Fetch with mem_ready stuck low ----
    @(negedge clk);
    req0 = 1'b1; addr0 = A0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_0000;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
`ifdef MEM_PORT_TIMEOUT_EN
      check($sformatf("tmo.c%0d.ack0", c),    ack0,    (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("tmo.c%0d.err", c),     err,     (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("tmo.c%0d.mem_req", c), mem_req, (c <= 8) ? 32'd1 : 32'd0);
      check($sformatf("tmo.c%0d.rdata", c),   rdata,   0);
`else
      check($sformatf("stuck.c%0d.ack0", c),    ack0,    0);
      check($sformatf("stuck.c%0d.err", c),     err,     0);
      check($sformatf("stuck.c%0d.mem_req", c), mem_req, 1);
`endif
      if (c == 8) req0 = 1'b0;
    end
    do_reset();

`ifdef MEM_PORT_TIMEOUT_EN
    // ---- mem_ready arriving on the timeout cycle wins ----
    @(negedge clk);
    req0 = 1'b1; addr0 = A0; mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) mem_ready = 1'b1;
      #1;
      check($sformatf("tmo_win.c%0d.ack0", c), ack0, (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("tmo_win.c%0d.err", c),  err,  0);
      if (c == 8) begin
        check("tmo_win.rdata", rdata, 32'h1234_5678);
        req0 = 1'b0;
      end
    end
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
